// File: rtl/byte_unloader.sv
// byte_unloader: serves byte-wide reads from a 16-bit word memory.
// A one-word cache means sequential reads fetch each word only once.
//
// Handshakes:
//   rd_in   : single-cycle request, sampled with addr_in. Accepted only in
//             IDLE with en=1; a request seen while a fetch is outstanding is
//             dropped and flagged on err.
//   mem_req : raised with a stable mem_addr and held until mem_ack. mem_ack
//             is a one-cycle strobe carrying mem_data in the same cycle.
//             An ack seen while no request is outstanding is ignored.
//   dout_valid: one-cycle strobe; dout holds its value between strobes.
module byte_unloader #(
  parameter int ADDR_W     = 17,
  parameter int BYTE_ORDER = 0,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rd_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [7:0]        dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic              state_dbg
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  localparam logic       BO       = (BYTE_ORDER != 0);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-2:0] cache_addr;
  logic [15:0]       cache_data;
  logic              cache_valid;
  logic [7:0]        cnt;
  logic              pend_sel;

  logic              req_sel;
  logic              hit;
  logic              start;
  logic              done;
  logic              tmo;
  logic              drop;

  // sel=0 picks the high byte, sel=1 the low byte.
  function automatic logic [7:0] pick(input logic [15:0] w, input logic s);
    return s ? w[7:0] : w[15:8];
  endfunction

  assign req_sel   = addr_in[0] ^ BO;
  assign state_dbg = (state == S_FETCH);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state and per-cycle events; en low overrides everything.
  always_comb begin
    state_d = state;
    hit     = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    drop    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_in) begin
            if (cache_valid && cache_addr == addr_in[ADDR_W-1:1]) begin
              hit = 1'b1;
            end else begin
              start   = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          drop = rd_in;
          // An ack on the timeout edge still completes normally.
          if (mem_ack) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else if (cnt == TMO_LAST) begin
            tmo     = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: cache, memory request, output byte and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout        <= 8'h00;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      cache_addr  <= '0;
      cache_data  <= 16'h0000;
      cache_valid <= 1'b0;
      cnt         <= 8'd0;
      pend_sel    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (!en) begin
        // Flush: abandon any fetch, forget the cache, clear the error.
        mem_req     <= 1'b0;
        busy        <= 1'b0;
        cache_valid <= 1'b0;
        cnt         <= 8'd0;
        err         <= 1'b0;
      end else begin
        if (hit) begin
          dout       <= pick(cache_data, req_sel);
          dout_valid <= 1'b1;
        end
        if (start) begin
          mem_addr <= addr_in[ADDR_W-1:1];
          mem_req  <= 1'b1;
          busy     <= 1'b1;
          cnt      <= 8'd0;
          pend_sel <= req_sel;
        end
        if (done) begin
          cache_data  <= mem_data;
          cache_addr  <= mem_addr;
          cache_valid <= 1'b1;
          dout        <= pick(mem_data, pend_sel);
          dout_valid  <= 1'b1;
          mem_req     <= 1'b0;
          busy        <= 1'b0;
        end else if (tmo) begin
          dout        <= 8'hFF;
          dout_valid  <= 1'b1;
          err         <= 1'b1;
          mem_req     <= 1'b0;
          busy        <= 1'b0;
          cache_valid <= 1'b0;
        end else if (state == S_FETCH) begin
          cnt <= cnt + 8'd1;
        end
        if (drop) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_unloader.sv
// Testbench for byte_unloader: directed table, multi-cycle corner cases,
// then sequential and random reads against a reference model.
module tb_byte_unloader;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        rd_in;
  logic [16:0] addr_in;
  logic        mem_ack;
  logic [15:0] mem_data;

  logic [7:0]  dout, dout1;
  logic        dout_valid, dv1;
  logic        busy, busy1, err, err1, mem_req, mem_req1, state_dbg, state_dbg1;
  logic [15:0] mem_addr, mem_addr1;

  byte_unloader #(.ADDR_W(17), .BYTE_ORDER(0), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .en(en), .rd_in(rd_in), .addr_in(addr_in),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .state_dbg(state_dbg)
  );

  byte_unloader #(.ADDR_W(17), .BYTE_ORDER(1), .TIMEOUT(TMO)) dut_bo1 (
    .clk(clk), .reset(reset), .en(en), .rd_in(rd_in), .addr_in(addr_in),
    .dout(dout1), .dout_valid(dv1), .busy(busy1), .err(err1),
    .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_ack(mem_ack),
    .mem_data(mem_data), .state_dbg(state_dbg1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int pulses = 0;
  int cur_len = 0;
  int last_len = 0;
  logic prev_req = 1'b0;
  int ack_lat = 0;       // 0 = never acknowledge
  logic stray_ack = 1'b0;
  int req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: a few fixed words, the rest a simple hash.
  function automatic logic [15:0] mem_word(input logic [15:0] w);
    int t;
    case (w)
      16'h0040: return 16'hA55A;
      16'h0041: return 16'h1234;
      16'h0042: return 16'hBEEF;
      16'h0043: return 16'hC3D4;
      default: begin
        t = int'(w) * 40503 + 12345;
        return t[15:0];
      end
    endcase
  endfunction

  // Byte at a byte address: offset within word XOR byte order picks
  // the high byte (0) or low byte (1).
  function automatic logic [7:0] exp_byte(input logic [16:0] a, input int bo);
    int w;
    int sel;
    w   = int'(mem_word(a[16:1]));
    sel = (int'(a[0]) + bo) % 2;
    return 8'((w >> (sel == 1 ? 0 : 8)) & 255);
  endfunction

  // ---------------- memory responder ----------------
  always @(posedge clk) begin
    #1;
    mem_data = 16'($urandom);
    mem_ack  = 1'b0;
    if (mem_req) begin
      req_cnt++;
      if (ack_lat != 0 && req_cnt == ack_lat) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_addr);
      end
    end else begin
      req_cnt = 0;
      mem_ack = stray_ack;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (dout_valid || dv1) begin
        chk("dv_pair", 32'(dv1), 32'(dout_valid));
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_dv: dout=%0h with no read outstanding, required no pulse", dout);
        end else begin
          chk("dout", 32'(dout), 32'(exp_q.pop_front()));
          if (exp1_q.size() != 0) chk("dout_bo1", 32'(dout1), 32'(exp1_q.pop_front()));
        end
      end
      if (mem_req && !prev_req) pulses++;
      if (mem_req) cur_len++;
      else if (prev_req) begin
        last_len = cur_len;
        cur_len  = 0;
      end
      prev_req = mem_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_rd(input logic [16:0] a);
    rd_in   = 1'b1;
    addr_in = a;
    @(posedge clk);
    #1;
    rd_in = 1'b0;
  endtask

  // Cycles from the sampling edge until dout_valid is seen (1 = next cycle).
  task automatic wait_dv(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        lat = c;
        #1;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL dv_timeout: no dout_valid within 40 cycles, required one");
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [16:0] addr;
    int          lat;    // ack latency, 0 = never
    bit          fetch;
    logic [7:0]  b0;     // expected byte, BYTE_ORDER=0
    logic [7:0]  b1;     // expected byte, BYTE_ORDER=1
    bit          err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat, p0, exp_lat, err_m, len_ok;
    logic        cvalid;
    logic [15:0] cword;
    logic [16:0] a;
    logic [7:0]  b;

    tbl[0] = '{17'h00080, 2, 1'b1, 8'hA5, 8'h5A, 1'b0};
    tbl[1] = '{17'h00081, 0, 1'b0, 8'h5A, 8'hA5, 1'b0};
    tbl[2] = '{17'h00080, 0, 1'b0, 8'hA5, 8'h5A, 1'b0};
    tbl[3] = '{17'h00082, 1, 1'b1, 8'h12, 8'h34, 1'b0};
    tbl[4] = '{17'h00083, 0, 1'b0, 8'h34, 8'h12, 1'b0};
    tbl[5] = '{17'h00084, 3, 1'b1, 8'hBE, 8'hEF, 1'b0};
    tbl[6] = '{17'h00080, 4, 1'b1, 8'hA5, 8'h5A, 1'b0};  // ack on timeout edge
    tbl[7] = '{17'h00085, 1, 1'b1, 8'hEF, 8'hBE, 1'b0};
    tbl[8] = '{17'h00086, 0, 1'b1, 8'hFF, 8'hFF, 1'b1};  // timeout
    tbl[9] = '{17'h00086, 1, 1'b1, 8'hC3, 8'hD4, 1'b1};  // refetch after timeout

    reset = 1'b1; en = 1'b0; rd_in = 1'b0; addr_in = '0;
    mem_ack = 1'b0; mem_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_dv", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    #1;

    // Table: each read is issued in the cycle the previous dout_valid appears.
    for (int i = 0; i < 10; i++) begin
      ack_lat = tbl[i].lat;
      p0 = pulses;
      exp_q.push_back(tbl[i].b0);
      exp1_q.push_back(tbl[i].b1);
      pulse_rd(tbl[i].addr);
      wait_dv(lat);
      exp_lat = !tbl[i].fetch ? 1 : (tbl[i].lat == 0 ? TMO + 1 : tbl[i].lat + 1);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("tbl%0d_fetches", i), 32'(pulses - p0), 32'(tbl[i].fetch));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_req_low", i), 32'(mem_req), 32'h0);
      if (tbl[i].fetch) chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr[16:1]));
      if (tbl[i].fetch && tbl[i].lat == 0) chk("tmo_req_len", 32'(last_len), 32'(TMO));
    end

    // Flush mid-fetch, stray ack, then the previously cached word refetches.
    ack_lat = 0;
    pulse_rd(17'h00080);
    @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("flush_req", 32'(mem_req), 32'h0);
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_err", 32'(err), 32'h0);
    chk("flush_dout_hold", 32'(dout), 32'hC3);
    en = 1'b1;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_busy", 32'(busy), 32'h0);
    chk("stray_req", 32'(mem_req), 32'h0);
    ack_lat = 1;
    p0 = pulses;
    exp_q.push_back(8'hC3);
    exp1_q.push_back(8'hD4);
    pulse_rd(17'h00086);
    wait_dv(lat);
    chk("refetch_lat", 32'(lat), 32'd2);
    chk("refetch_count", 32'(pulses - p0), 32'd1);

    // Dropped request during a fetch, with the ack racing the timeout edge.
    ack_lat = 4;
    p0 = pulses;
    exp_q.push_back(8'hBE);
    exp1_q.push_back(8'hEF);
    pulse_rd(17'h00084);
    pulse_rd(17'h00101);
    chk("drop_err", 32'(err), 32'h1);
    chk("drop_addr", 32'(mem_addr), 32'h0042);
    chk("drop_busy", 32'(busy), 32'h1);
    wait_dv(lat);
    chk("drop_lat", 32'(lat), 32'd4);
    chk("drop_count", 32'(pulses - p0), 32'd1);
    chk("drop_err_after", 32'(err), 32'h1);

    // Asynchronous reset between edges during a fetch.
    ack_lat = 0;
    pulse_rd(17'h00200);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 32'h00);
    chk("arst_dv", 32'(dout_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_req", 32'(mem_req), 32'h0);
    chk("arst_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Throughput: 256 sequential bytes need exactly 128 fetches.
    p0 = pulses;
    len_ok = 0;
    for (int i = 0; i < 256; i++) begin
      a = 17'h00400 + 17'(i);
      ack_lat = $urandom_range(1, 3);
      exp_q.push_back(exp_byte(a, 0));
      exp1_q.push_back(exp_byte(a, 1));
      pulse_rd(a);
      wait_dv(lat);
      exp_lat = (i % 2 == 1) ? 1 : ack_lat + 1;
      if (lat == exp_lat) len_ok++;
    end
    chk("seq_latencies_ok", 32'(len_ok), 32'd256);
    chk("seq_fetches", 32'(pulses - p0), 32'd128);

    // Random reads over a small window, with random latency incl. timeouts.
    cvalid = 1'b0;
    cword  = '0;
    err_m  = 0;
    for (int i = 0; i < 80; i++) begin
      a = 17'h00200 + 17'($urandom_range(0, 31));
      ack_lat = $urandom_range(0, TMO);
      p0 = pulses;
      if (cvalid && cword == a[16:1]) begin
        exp_lat = 1;
        exp_q.push_back(exp_byte(a, 0));
        exp1_q.push_back(exp_byte(a, 1));
      end else if (ack_lat == 0) begin
        exp_lat = TMO + 1;
        exp_q.push_back(8'hFF);
        exp1_q.push_back(8'hFF);
        cvalid = 1'b0;
        err_m  = 1;
      end else begin
        exp_lat = ack_lat + 1;
        exp_q.push_back(exp_byte(a, 0));
        exp1_q.push_back(exp_byte(a, 1));
        cvalid = 1'b1;
        cword  = a[16:1];
      end
      pulse_rd(a);
      wait_dv(lat);
      b = 8'(exp_lat);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(b));
      chk($sformatf("rnd%0d_fetches", i), 32'(pulses - p0), 32'(exp_lat == 1 ? 0 : 1));
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'(err_m));
    end

    repeat (3) @(negedge clk);
    chk("pending_expect", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/byte_unloader.md
# byte_unloader

Read-side counterpart of the ROM/RAM byte loading path. Serves byte-wide read requests from the HPS upload interface (save data, high scores) out of 16-bit word memory. Splits each byte address into a word fetch plus a byte select and keeps a one-word cache, so sequential reads cost one memory access per two bytes. Sits between the HPS I/O upload port and the word-wide memory arbiter port.

## Interface

Parameters:
- ADDR_W, 17, byte address width; the word address is ADDR_W-1 bits.
- BYTE_ORDER, 0, 0: even byte = mem_data[15:8]; 1: even byte = mem_data[7:0].
- TIMEOUT, 15, maximum cycles waiting for mem_ack before abort (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  upload active; low = synchronous flush to idle
- rd_in  in  1  one-cycle byte read request
- addr_in  in  ADDR_W  byte address, sampled with rd_in
- dout  out  8  read byte, held until the next update
- dout_valid  out  1  one-cycle pulse, dout updated this cycle
- busy  out  1  memory fetch in progress; rd_in ignored
- err  out  1  sticky: request dropped or fetch timed out
- mem_req  out  1  word read request, held until acknowledged
- mem_addr  out  ADDR_W-1  word address, stable while mem_req high
- mem_ack  in  1  one-cycle acknowledge; mem_data valid in the same cycle
- mem_data  in  16  word read data

## Operation

- Reset values: dout=8'h00, dout_valid=0, busy=0, err=0, mem_req=0, mem_addr=0. Cache invalid, timeout counter 0, state IDLE.
- Cache state: cache_addr (ADDR_W-1), cache_data (16), cache_valid.
- Byte select: sel = addr_in[0] XOR BYTE_ORDER. sel=0 gives data[15:8]; sel=1 gives data[7:0]. The pending sel is registered at request time.
- States:
  - IDLE: on rd_in with en=1:
    - Hit (cache_valid and cache_addr == addr_in[ADDR_W-1:1]): dout gets the selected cache byte and dout_valid=1 at the next edge. Stay in IDLE.
    - Miss: mem_addr = addr_in[ADDR_W-1:1], mem_req=1, busy=1, counter=0. Go to FETCH.
  - FETCH:
    - On mem_ack: cache_data = mem_data, cache_addr = mem_addr, cache_valid=1. dout gets the selected byte of mem_data, dout_valid=1, mem_req=0, busy=0. Go to IDLE.
    - Otherwise the counter increments. When the counter equals TIMEOUT-1 and no ack arrives: dout=8'hFF, dout_valid=1, err=1, mem_req=0, busy=0, cache_valid=0. Go to IDLE.
- rd_in while in FETCH is dropped, sets err=1, and does not change mem_addr or the pending sel.
- mem_ack while mem_req=0 is ignored.
- en=0, checked ahead of everything else, at the next edge:
  - state IDLE, mem_req=0, busy=0, dout_valid=0;
  - cache_valid=0, counter=0, err=0;
  - dout holds its value.
- en=0 mid-fetch abandons the request with no dout_valid. A late mem_ack is ignored.
- Reset mid-fetch: all registers go to their reset values immediately (asynchronous).

## Timing

- Requests are sampled at edge 0.
- Hit: dout_valid high in cycle 1. Back-to-back hits are accepted every cycle, giving one byte per cycle.
- Miss: mem_req and mem_addr are registered, high from cycle 1. With mem_ack sampled at edge k (k ≥ 1), dout_valid is high in cycle k+1, and mem_req and busy are low in cycle k+1.
- A new rd_in in cycle k+1 (same cycle as dout_valid) is accepted.
- Timeout: mem_req is high for exactly TIMEOUT cycles; dout_valid=8'hFF appears in cycle TIMEOUT+1.
- mem_ack arriving on the same edge as the timeout wins: normal completion, no err.
- rd_in is accepted in the same cycle as the en 0→1 rise if en is high at that edge.

## Test plan

- Sequential miss then hit: reset, en=1, memory word 0x0040=16'hA55A with ack latency 2. rd_in addr=0x00080 → mem_req with mem_addr=0x0040, dout=8'hA5 pulse. rd_in addr=0x00081 → no mem_req, dout=8'h5A one cycle later.
- BYTE_ORDER=1 with the same stimulus: dout sequence 8'h5A then 8'hA5.
- Timeout: TIMEOUT=4, mem_ack never asserted → mem_req high exactly 4 cycles, then dout=8'hFF, err=1. A following read to the same word issues mem_req again (cache invalidated).
- Dropped request: rd_in during FETCH with a different addr → mem_addr unchanged, err=1, only one dout_valid. Ack/timeout race at edge TIMEOUT → data returned, err from the drop only.
- Flush: en low during FETCH → mem_req=0 next cycle, no dout_valid, err=0. A stray mem_ack afterwards → no effect. Re-enable and read the cached address → fetch reissued.
- Async reset asserted mid-fetch between edges → all outputs zero before the next clock edge. Throughput check: 256 sequential bytes → exactly 128 mem_req pulses.
